// File: rtl/sparse_pkg.sv
// Shared constants and types for the sparse MAC datapath.
// Holds lane/accumulator defaults, nibble geometry and the group FSM state.
package sparse_pkg;

  localparam int LANES_DEF = 14;
  localparam int NIB_W     = 4;
  localparam int NNZ       = 8;
  localparam int BEAT_W    = NIB_W * NNZ;
  localparam int LSUM_W    = 11;
  localparam int ACC_W_DEF = 20;
  localparam int LEN_W     = 8;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

endpackage

// File: rtl/sparse_mac_lane.sv
// One activation lane: 8 nibble multipliers, adder tree, stage-1 register,
// accumulator and result register.
// Ports: clk, rst_n, in_valid, act, weight (stage-0 beat);
//   beat, load, close (stage-1 group control from the shared FSM);
//   psum (held lane result).
// Build option: SPARSE_MAC_SAT_EN selects saturating accumulation,
//   otherwise the accumulator wraps modulo 2^ACC_W.
module sparse_mac_lane
  import sparse_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [BEAT_W-1:0] act,
  input  logic [BEAT_W-1:0] weight,
  input  logic              beat,
  input  logic              load,
  input  logic              close,
  output logic [ACC_W-1:0]  psum
);

  localparam int EXT = LSUM_W - NIB_W;

  logic signed [LSUM_W-1:0] prod [NNZ];
  logic signed [LSUM_W-1:0] lvl1 [NNZ/2];
  logic signed [LSUM_W-1:0] lvl2 [NNZ/4];
  logic signed [LSUM_W-1:0] lsum_d;
  logic signed [LSUM_W-1:0] lsum_q;

  logic signed [ACC_W-1:0] lsum_x;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] sum;
  logic [ACC_W-1:0]        psum_q;

  // activations are unsigned, weights signed; both widened to LSUM_W
  always_comb begin
    for (int n = 0; n < NNZ; n++) begin
      prod[n] = $signed({{EXT{1'b0}}, act[n*NIB_W +: NIB_W]})
              * $signed({{EXT{weight[n*NIB_W+NIB_W-1]}},
                         weight[n*NIB_W +: NIB_W]});
    end
    for (int i = 0; i < NNZ/2; i++) begin
      lvl1[i] = prod[2*i] + prod[2*i+1];
    end
    for (int i = 0; i < NNZ/4; i++) begin
      lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    end
    lsum_d = lvl2[0] + lvl2[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsum_q <= '0;
    end else if (in_valid) begin
      lsum_q <= lsum_d;
    end
  end

  assign lsum_x = {{(ACC_W-LSUM_W){lsum_q[LSUM_W-1]}}, lsum_q};

`ifdef SPARSE_MAC_SAT_EN
  logic signed [ACC_W:0] wide;

  assign wide = {acc_q[ACC_W-1], acc_q} + {lsum_x[ACC_W-1], lsum_x};

  // top two bits disagree only on overflow; the carry bit gives direction
  always_comb begin
    sum = wide[ACC_W-1:0];
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                        : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum = acc_q + lsum_x;
`endif

  // a flush without a beat closes with the held accumulator
  always_comb begin
    acc_d = acc_q;
    if (beat) begin
      acc_d = load ? lsum_x : sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      psum_q <= '0;
    end else begin
      if (beat) begin
        acc_q <= acc_d;
      end
      if (close) begin
        psum_q <= acc_d;
      end
    end
  end

  assign psum = psum_q;

endmodule

// File: rtl/sparse_mac_14groups.sv
// Grouped sparse multiply-accumulate across LANES activation lanes.
// Ports: clk, rst_n (async, active-low), in_valid, valid_act, weight_val,
//   acc_len, flush (inputs); out_valid pulse and psum (outputs).
// Build option: SPARSE_MAC_SAT_EN makes lane accumulators saturate.
module sparse_mac_14groups
  import sparse_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [BEAT_W*LANES-1:0] valid_act,
  input  logic [BEAT_W-1:0]       weight_val,
  input  logic [LEN_W-1:0]        acc_len,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [ACC_W*LANES-1:0]  psum
);

  state_t             state_q;
  state_t             state_d;
  logic               s1_valid;
  logic               s1_flush;
  logic [LEN_W-1:0]   s1_len;
  logic [LEN_W-1:0]   beat_cnt;
  logic [LEN_W-1:0]   cnt_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_d;
  logic               load;
  logic               close;
  logic               out_valid_q;

  // acc_len rides with its beat so it is seen in stage-1 alignment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_flush <= 1'b0;
      s1_len   <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_flush <= flush;
      if (in_valid) begin
        s1_len <= acc_len;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = beat_cnt;
    len_d   = len_q;
    load    = 1'b0;
    close   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s1_valid) begin
          load    = 1'b1;
          cnt_d   = 8'd1;
          len_d   = (s1_len == '0) ? 8'd1 : s1_len;
          close   = (len_d == 8'd1) || s1_flush;
          state_d = close ? IDLE : ACCUM;
        end
      end
      ACCUM: begin
        if (s1_valid) begin
          cnt_d = beat_cnt + 8'd1;
          close = (cnt_d == len_q) || s1_flush;
        end else begin
          close = s1_flush;
        end
        if (close) begin
          state_d = IDLE;
        end
      end
    endcase
    if (close) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt    <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt    <= cnt_d;
      len_q       <= len_d;
      out_valid_q <= close;
    end
  end

  assign out_valid = out_valid_q;

  for (genvar m = 0; m < LANES; m++) begin : g_lane
    sparse_mac_lane #(
      .ACC_W (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .act      (valid_act[m*BEAT_W +: BEAT_W]),
      .weight   (weight_val),
      .beat     (s1_valid),
      .load     (load),
      .close    (close),
      .psum     (psum[m*ACC_W +: ACC_W])
    );
  end

endmodule

// File: tb/tb_sparse_mac_14groups.sv
// Self-checking bench for sparse_mac_14groups (default and ACC_W=12 copies).
// Group-level reference model predicts each pulse and the held psum.
module tb_sparse_mac_14groups;

  localparam int L    = 14;
  localparam int AW   = 20;
  localparam int AW12 = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              flush = 1'b0;
  logic [32*L-1:0]   valid_act = '0;
  logic [31:0]       weight_val = '0;
  logic [7:0]        acc_len = '0;
  logic              out_valid;
  logic              out_valid12;
  logic [AW*L-1:0]   psum;
  logic [AW12*L-1:0] psum12;

  always #5 clk = ~clk;

  sparse_mac_14groups dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .valid_act  (valid_act),
    .weight_val (weight_val),
    .acc_len    (acc_len),
    .flush      (flush),
    .out_valid  (out_valid),
    .psum       (psum)
  );

  sparse_mac_14groups #(.ACC_W(AW12)) dut12 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .valid_act  (valid_act),
    .weight_val (weight_val),
    .acc_len    (acc_len),
    .flush      (flush),
    .out_valid  (out_valid12),
    .psum       (psum12)
  );

  int checks = 0;
  int failures = 0;
  int ncall = 0;

  bit m_open = 0;
  int m_cnt = 0;
  int m_len = 0;
  int m_sum [L];
  int m_last [L];
  bit pend_v = 0;
  int pend_sum [L];

  bit              obs_v;
  bit              obs_v12;
  logic [AW*L-1:0] obs_psum;
  logic [AW12*L-1:0] obs_psum12;

  function automatic int lane_sum(input logic [31:0] a,
                                  input logic [31:0] w);
    int s = 0;
    logic [3:0] an;
    logic signed [3:0] wn;
    for (int n = 0; n < 8; n++) begin
      an = a[n*4 +: 4];
      wn = w[n*4 +: 4];
      s += int'(an) * int'(wn);
    end
    return s;
  endfunction

  function automatic logic [31:0] act_for_sum(input int s);
    logic [31:0] r = '0;
    int k;
    int left = s;
    for (int n = 0; n < 8; n++) begin
      k = (left > 15) ? 15 : left;
      r[n*4 +: 4] = k[3:0];
      left -= k;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_w();
    logic [31:0] r;
    int k;
    for (int n = 0; n < 8; n++) begin
      k = $urandom_range(1, 15);
      r[n*4 +: 4] = k[3:0];
    end
    return r;
  endfunction

  function automatic logic [32*L-1:0] rand_act();
    logic [32*L-1:0] r;
    for (int m = 0; m < L; m++) r[m*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic model_clear();
    m_open = 0;
    m_cnt = 0;
    pend_v = 0;
    for (int m = 0; m < L; m++) m_last[m] = 0;
  endtask

  // one clock: drive a beat, predict, then check the previous beat's result
  task automatic do_cycle(input bit v, input bit f, input logic [7:0] len,
                          input logic [32*L-1:0] a, input logic [31:0] w);
    bit close = 0;
    logic [AW*L-1:0] exp_vec;
    int t;
    in_valid = v;
    flush = f;
    acc_len = len;
    valid_act = a;
    weight_val = w;
    if (v) begin
      if (!m_open) begin
        m_open = 1;
        m_cnt = 1;
        m_len = (len == 0) ? 1 : int'(len);
        for (int m = 0; m < L; m++) m_sum[m] = lane_sum(a[m*32 +: 32], w);
      end else begin
        m_cnt++;
        for (int m = 0; m < L; m++) m_sum[m] += lane_sum(a[m*32 +: 32], w);
      end
      if (m_cnt == m_len || f) close = 1;
    end else if (f && m_open) begin
      close = 1;
    end
    if (close) m_open = 0;
    @(posedge clk);
    @(negedge clk);
    ncall++;
    if (pend_v) m_last = pend_sum;
    for (int m = 0; m < L; m++) begin
      t = m_last[m];
      exp_vec[m*AW +: AW] = t[AW-1:0];
    end
    checks++;
    if (out_valid !== pend_v) begin
      failures++;
      $display("FAIL out_valid call=%0d got=%0b exp=%0b",
               ncall, out_valid, pend_v);
    end
    checks++;
    if (psum !== exp_vec) begin
      failures++;
      $display("FAIL psum call=%0d got=%h exp=%h", ncall, psum, exp_vec);
    end
    obs_v = out_valid;
    obs_v12 = out_valid12;
    obs_psum = psum;
    obs_psum12 = psum12;
    pend_v = close;
    if (close) pend_sum = m_sum;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 8'd0, rand_act(), rand_w());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || psum !== '0) begin
      failures++;
      $display("FAIL reset_state got=%0b/%h exp=0/0", out_valid, psum);
    end
    rst_n = 1'b1;
    model_clear();
    idle(2);
  endtask

  task automatic test_single_beat();
    int bad = 0;
    logic [32*L-1:0] a = '1;
    do_cycle(1, 0, 8'd1, a, 32'h7777_7777);
    idle(1);
    for (int m = 0; m < L; m++)
      if ($signed(obs_psum[m*AW +: AW]) != 840) bad++;
    checks++;
    if (!obs_v || bad != 0) begin
      failures++;
      $display("FAIL single_beat got=%0b bad_lanes=%0d exp=1/0", obs_v, bad);
    end
    idle(1);
  endtask

  task automatic test_multi_beat();
    logic [32*L-1:0] a;
    int pulses = 0;
    int early = 0;
    int lane0 = 0;
    for (int b = 0; b < 4; b++) begin
      a = rand_act();
      a[31:0] = 32'h1111_1111;
      do_cycle(1, 0, 8'd4, a, 32'h8888_8888);
      if (obs_v) early++;
    end
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 0, 8'd4, rand_act(), rand_w());
      if (obs_v) begin
        pulses++;
        lane0 = $signed(obs_psum[AW-1:0]);
      end
    end
    checks++;
    if (early != 0 || pulses != 1 || lane0 != -256) begin
      failures++;
      $display("FAIL multi_beat got=%0d/%0d/%0d exp=0/1/-256",
               early, pulses, lane0);
    end
  endtask

  task automatic test_back_to_back();
    logic [32*L-1:0] a;
    int vals [$];
    int when [$];
    for (int b = 0; b < 6; b++) begin
      if (b < 4) begin
        a = rand_act();
        a[31:0] = act_for_sum(10 * (b + 1));
        do_cycle(1, 0, 8'd2, a, 32'h1111_1111);
      end else begin
        do_cycle(0, 0, 8'd2, rand_act(), rand_w());
      end
      if (obs_v) begin
        vals.push_back($signed(obs_psum[AW-1:0]));
        when.push_back(ncall);
      end
    end
    checks++;
    if (vals.size() != 2) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=2", vals.size());
    end else begin
      checks++;
      if (vals[0] != 30 || vals[1] != 70 || when[1] - when[0] != 2) begin
        failures++;
        $display("FAIL b2b_values got=%0d,%0d gap=%0d exp=30,70 gap=2",
                 vals[0], vals[1], when[1] - when[0]);
      end
    end
  endtask

  task automatic test_flush();
    logic [32*L-1:0] a;
    int pulses = 0;
    int lane0 = 0;
    for (int b = 0; b < 3; b++) begin
      a = rand_act();
      a[31:0] = 32'h0000_0005;
      do_cycle(1, 0, 8'd8, a, 32'h1111_1111);
      if (obs_v) pulses++;
    end
    do_cycle(0, 1, 8'd8, rand_act(), rand_w());
    if (obs_v) pulses++;
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 0, 8'd8, rand_act(), rand_w());
      if (obs_v) begin
        pulses++;
        lane0 = $signed(obs_psum[AW-1:0]);
      end
    end
    checks++;
    if (pulses != 1 || lane0 != 15) begin
      failures++;
      $display("FAIL flush_accum got=%0d/%0d exp=1/15", pulses, lane0);
    end
    pulses = 0;
    do_cycle(0, 1, 8'd8, rand_act(), rand_w());
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 0, 8'd8, rand_act(), rand_w());
      if (obs_v) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL flush_idle got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [32*L-1:0] a;
    int pulses = 0;
    int lane0 = 0;
    for (int b = 0; b < 2; b++) begin
      a = rand_act();
      a[31:0] = 32'h0000_0001;
      do_cycle(1, 0, 8'd4, a, 32'h1111_1111);
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || psum !== '0 || psum12 !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got=%0b/%h exp=0/0", out_valid, psum);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 0, 8'd4, rand_act(), rand_w());
      if (obs_v) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL reset_discard got=%0d exp=0", pulses);
    end
    for (int b = 0; b < 6; b++) begin
      if (b < 4) begin
        a = rand_act();
        a[31:0] = 32'h0000_0001;
        do_cycle(1, 0, 8'd4, a, 32'h1111_1111);
      end else begin
        do_cycle(0, 0, 8'd4, rand_act(), rand_w());
      end
      if (obs_v) lane0 = $signed(obs_psum[AW-1:0]);
    end
    checks++;
    if (lane0 != 4) begin
      failures++;
      $display("FAIL reset_restart got=%0d exp=4", lane0);
    end
  endtask

  task automatic test_random();
    bit v;
    bit f;
    int len;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 9) == 0);
      len = $urandom_range(0, 5);
      do_cycle(v, f, len[7:0], rand_act(), rand_w());
    end
    do_cycle(0, 1, 8'd0, rand_act(), rand_w());
    idle(3);
  endtask

  task automatic test_saturation();
    logic [32*L-1:0] a = '1;
    int bad = 0;
    int seen = 0;
    int expv;
`ifdef SPARSE_MAC_SAT_EN
    expv = 2047;
`else
    expv = -1576;
`endif
    for (int b = 0; b < 5; b++) begin
      if (b < 3) do_cycle(1, 0, 8'd3, a, 32'h7777_7777);
      else do_cycle(0, 0, 8'd3, rand_act(), rand_w());
      if (obs_v12) begin
        seen++;
        for (int m = 0; m < L; m++)
          if ($signed(obs_psum12[m*AW12 +: AW12]) != expv) bad++;
      end
    end
    checks++;
    if (seen != 1 || bad != 0) begin
      failures++;
      $display("FAIL saturation got=pulses %0d bad_lanes %0d lane0 %0d exp=1/0/%0d",
               seen, bad, $signed(obs_psum12[AW12-1:0]), expv);
    end
  endtask

  initial begin
    for (int m = 0; m < L; m++) begin
      m_sum[m] = 0;
      m_last[m] = 0;
      pend_sum[m] = 0;
    end
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
